// File: rtl/irc_pkg.sv
// Shared definitions for the IRC carrier path: FSM states, carrier timing
// defaults at 100 MHz, and the period/high sanitise helpers used at config load.
package irc_pkg;

  localparam int unsigned IRC_CNT_W      = 16;

  // 100 MHz / 38 kHz and 100 MHz / 36 kHz, ~50 % duty
  localparam int unsigned DEF_PERIOD_38K = 2631;
  localparam int unsigned DEF_HIGH_38K   = 1315;
  localparam int unsigned DEF_PERIOD_36K = 2778;
  localparam int unsigned DEF_HIGH_36K   = 1389;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MARK = 2'd1,
    TAIL = 2'd2
  } irc_state_e;

  // A period below 2 cannot hold both a high and a low phase.
  function automatic logic [31:0] irc_sanitise_period(input logic [31:0] period);
    return (period < 32'd2) ? 32'd2 : period;
  endfunction

  // High time must leave at least one low cycle per period.
  function automatic logic [31:0] irc_sanitise_high(input logic [31:0] period_eff,
                                                     input logic [31:0] high);
    return (high > (period_eff - 32'd1)) ? (period_eff - 32'd1) : high;
  endfunction

endpackage

// File: rtl/irc_cfg_shadow.sv
// Pending/active config register pair with boundary-gated apply.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   load              capture load_period/load_high (sanitised) as pending
//   load_period/high  requested config
//   apply_ok          current cycle is a safe boundary for switching config
//   act_period/high   active config (registered)
//   next_high_c       active high time as it will be after this cycle
//   pending           a loaded config is waiting for a boundary (registered)
module irc_cfg_shadow
  import irc_pkg::*;
#(
  parameter int unsigned CNT_W      = IRC_CNT_W,
  parameter int unsigned DEF_PERIOD = DEF_PERIOD_38K,
  parameter int unsigned DEF_HIGH   = DEF_HIGH_38K
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_period,
  input  logic [CNT_W-1:0] load_high,
  input  logic             apply_ok,
  output logic [CNT_W-1:0] act_period,
  output logic [CNT_W-1:0] act_high,
  output logic [CNT_W-1:0] next_high_c,
  output logic             pending
);

  logic [CNT_W-1:0] act_period_q, act_period_d;
  logic [CNT_W-1:0] act_high_q, act_high_d;
  logic [CNT_W-1:0] pend_period_q, pend_period_d;
  logic [CNT_W-1:0] pend_high_q, pend_high_d;
  logic             pending_q, pending_d;
  logic [CNT_W-1:0] per_eff_c, high_eff_c;
  logic             apply_c;

  // Apply first, then load: a load coinciding with an apply stays pending.
  always_comb begin
    per_eff_c     = CNT_W'(irc_sanitise_period(32'(load_period)));
    high_eff_c    = CNT_W'(irc_sanitise_high(32'(per_eff_c), 32'(load_high)));
    apply_c       = apply_ok & pending_q;
    act_period_d  = act_period_q;
    act_high_d    = act_high_q;
    pend_period_d = pend_period_q;
    pend_high_d   = pend_high_q;
    pending_d     = pending_q;
    if (apply_c) begin
      act_period_d = pend_period_q;
      act_high_d   = pend_high_q;
      pending_d    = 1'b0;
    end
    if (load) begin
      pend_period_d = per_eff_c;
      pend_high_d   = high_eff_c;
      pending_d     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_period_q  <= CNT_W'(DEF_PERIOD);
      act_high_q    <= CNT_W'(DEF_HIGH);
      pend_period_q <= '0;
      pend_high_q   <= '0;
      pending_q     <= 1'b0;
    end else begin
      act_period_q  <= act_period_d;
      act_high_q    <= act_high_d;
      pend_period_q <= pend_period_d;
      pend_high_q   <= pend_high_d;
      pending_q     <= pending_d;
    end
  end

  assign act_period  = act_period_q;
  assign act_high    = act_high_q;
  assign next_high_c = act_high_d;
  assign pending     = pending_q;

endmodule

// File: rtl/irc_carrier_mod.sv
// IR carrier modulator: turns each tx mark into a phase-aligned carrier burst,
// or passes tx through registered when modulation is off.
// Optional build macro IRC_MARK_STATS_EN adds mark_cycles/mark_done.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   mod_en             1 = carrier modulation, 0 = registered pass-through
//   tx                 baseband data from the framer
//   cfg_period/high    requested carrier period / high time (cycles)
//   cfg_load           capture cfg_period/cfg_high as pending
//   cfg_pending        loaded config waiting for a period boundary
//   tx_mod             modulated output (registered)
//   mark_active        FSM is in MARK or TAIL (registered)
//   mark_cycles        [stats] completed periods of the last mark, saturating
//   mark_done          [stats] one-cycle pulse when a mark ends
module irc_carrier_mod
  import irc_pkg::*;
#(
  parameter int unsigned CNT_W         = IRC_CNT_W,
  parameter int unsigned DEF_PERIOD    = DEF_PERIOD_38K,
  parameter int unsigned DEF_HIGH      = DEF_HIGH_38K,
  parameter bit          TX_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mod_en,
  input  logic             tx,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic             cfg_load,
  output logic             cfg_pending,
  output logic             tx_mod,
  output logic             mark_active
`ifdef IRC_MARK_STATS_EN
  ,
  output logic [15:0]      mark_cycles,
  output logic             mark_done
`endif
);

  irc_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tx_mod_q, tx_mod_d;
  logic             mark_active_q, mark_active_d;

  logic [CNT_W-1:0] act_period, act_high, next_high_c;
  logic             mark_c, wrap_c, boundary_c, more_high_c;
  logic [CNT_W-1:0] cnt_nxt_c;
  logic [CNT_W:0]   cnt_inc_c;

  irc_cfg_shadow #(
    .CNT_W      (CNT_W),
    .DEF_PERIOD (DEF_PERIOD),
    .DEF_HIGH   (DEF_HIGH)
  ) u_cfg (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (cfg_load),
    .load_period (cfg_period),
    .load_high   (cfg_high),
    .apply_ok    (boundary_c),
    .act_period  (act_period),
    .act_high    (act_high),
    .next_high_c (next_high_c),
    .pending     (cfg_pending)
  );

  // Counter helpers; more_high_c means the current high phase has cycles left.
  always_comb begin
    mark_c      = TX_ACTIVE_LOW ? ~tx : tx;
    wrap_c      = (cnt_q == (act_period - CNT_W'(1)));
    cnt_nxt_c   = wrap_c ? '0 : (cnt_q + CNT_W'(1));
    cnt_inc_c   = {1'b0, cnt_q} + (CNT_W+1)'(1);
    more_high_c = (cnt_inc_c < {1'b0, act_high});
    boundary_c  = (state_q == IDLE) || wrap_c;
  end

  // Carrier FSM next state; tx_mod uses the config that is active after this
  // edge so a newly applied period starts with its own high phase.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tx_mod_d = tx_mod_q;
    if (!mod_en) begin
      state_d  = IDLE;
      cnt_d    = '0;
      tx_mod_d = tx;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d    = '0;
          tx_mod_d = 1'b0;
          if (mark_c) begin
            state_d  = MARK;
            tx_mod_d = (next_high_c != '0);
          end
        end
        MARK, TAIL: begin
          if (mark_c) begin
            state_d  = MARK;
            cnt_d    = cnt_nxt_c;
            tx_mod_d = (cnt_nxt_c < next_high_c);
          end else if (more_high_c) begin
            state_d  = TAIL;
            cnt_d    = cnt_nxt_c;
            tx_mod_d = 1'b1;
          end else begin
            state_d  = IDLE;
            cnt_d    = '0;
            tx_mod_d = 1'b0;
          end
        end
        default: begin
          state_d  = IDLE;
          cnt_d    = '0;
          tx_mod_d = 1'b0;
        end
      endcase
    end
    mark_active_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      tx_mod_q      <= 1'b0;
      mark_active_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tx_mod_q      <= tx_mod_d;
      mark_active_q <= mark_active_d;
    end
  end

  assign tx_mod      = tx_mod_q;
  assign mark_active = mark_active_q;

`ifdef IRC_MARK_STATS_EN
  logic [15:0] mark_cycles_q, mark_cycles_d;
  logic        mark_done_q, mark_done_d;

  // Per-mark period counter: cleared on mark start, held after mark end.
  always_comb begin
    mark_cycles_d = mark_cycles_q;
    mark_done_d   = 1'b0;
    if ((state_q == IDLE) && (state_d != IDLE)) begin
      mark_cycles_d = '0;
    end else if ((state_q != IDLE) && (state_d == IDLE)) begin
      mark_done_d = 1'b1;
    end else if ((state_q != IDLE) && wrap_c && (mark_cycles_q != 16'hFFFF)) begin
      mark_cycles_d = mark_cycles_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mark_cycles_q <= '0;
      mark_done_q   <= 1'b0;
    end else begin
      mark_cycles_q <= mark_cycles_d;
      mark_done_q   <= mark_done_d;
    end
  end

  assign mark_cycles = mark_cycles_q;
  assign mark_done   = mark_done_q;
`endif

endmodule

// File: doc/irc_carrier_mod.md
Name: irc_carrier_mod

Overview:
Parametrised IR carrier modulator for the IRC transmit path, placed between the UART/IRC framer and the LED driver pin. When modulation is enabled, each mark (active level on tx) becomes a phase-aligned carrier burst with runtime-programmable period and high time. When modulation is disabled, tx passes through registered. Carrier config changes apply glitch-free, and a mark never ends in a truncated high pulse.

Parameters:
CNT_W, 16, width of the period/high counters and config ports
DEF_PERIOD, 2631, reset carrier period in clk cycles (100 MHz / 38 kHz)
DEF_HIGH, 1315, reset carrier high time in clk cycles
TX_ACTIVE_LOW, 1, 1: a mark is tx=0; 0: a mark is tx=1

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
mod_en  in  1  1 = carrier modulation, 0 = registered pass-through
tx  in  1  baseband data from the framer
cfg_period  in  CNT_W  requested carrier period, in cycles
cfg_high  in  CNT_W  requested high time, in cycles
cfg_load  in  1  single-cycle pulse that captures cfg_period/cfg_high into the pending registers
cfg_pending  out  1  1 = a loaded config is waiting for a period boundary
tx_mod  out  1  modulated output, registered
mark_active  out  1  1 when the FSM is in MARK or TAIL

Behaviour:
- Reset values: tx_mod=0, mark_active=0, cfg_pending=0, cnt=0, state=IDLE, active config = DEF_PERIOD/DEF_HIGH.
- mark = tx XOR (TX_ACTIVE_LOW==0 ? 0 : 1). tx is sampled in the same cycle it is used. tx_mod is registered, so latency is 1 clk in both modes.
- Config sanitising happens at load:
  - period_eff = max(cfg_period, 2).
  - high_eff = min(cfg_high, period_eff-1).
  - high_eff=0 is legal and gives tx_mod=0 for the whole mark.
- Config apply:
  - cfg_load sets cfg_pending=1 and overwrites any pending value; the last load wins.
  - Pending config moves to active when state=IDLE, or when cnt==period-1 while in MARK or TAIL. cfg_pending clears in that same cycle.
  - cfg_load in the same cycle as an apply: the new value stays pending and the older pending value is applied.
- FSM, state transitions evaluated only when mod_en=1:
  - IDLE: cnt held at 0, tx_mod<=0. On mark: go to MARK with cnt=0, and tx_mod<=(high>0) in that same cycle. This keeps the carrier phase aligned to the mark edge.
  - MARK: cnt wraps from period-1 to 0; tx_mod<=(cnt<high) using the next cnt value.
    - mark drops while cnt<high-1: go to TAIL (finish the current high phase).
    - otherwise on mark drop: go to IDLE, tx_mod<=0.
  - TAIL: counting continues, tx_mod stays high until cnt reaches high, then tx_mod<=0 and go to IDLE.
    - mark reasserted in TAIL: go back to MARK without resetting cnt, so the carrier continues.
- Pass-through: mod_en=0 gives tx_mod<=tx (raw level, no polarity inversion).
  - Taking mod_en low forces state=IDLE and cnt=0 immediately, even mid-mark.
  - Raising mod_en while a mark is present starts MARK on the next cycle.
- Counter wraps only at period-1. It never overflows, because period ≤ 2^CNT_W-1.
- rst_n low mid-burst: all registers return to reset values next edge, and the pending config is discarded.

Optional Feature:
IRC_MARK_STATS_EN:
- Defined: adds output mark_cycles[15:0] and output mark_done (1-cycle pulse).
  - mark_cycles counts completed carrier periods (cnt wraps) in the current mark, saturating at 0xFFFF.
  - The count is latched and mark_done pulses on the cycle the FSM enters IDLE from MARK/TAIL.
  - The count is cleared on IDLE→MARK.
- Undefined: neither port exists and there is no counter logic. Core behaviour is identical.

Decomposition:
- Shared package irc_pkg holds:
  - state enum (IDLE, MARK, TAIL)
  - constants DEF_PERIOD/DEF_HIGH for 38 kHz and 36 kHz at 100 MHz
  - a sanitise function for the period/high clamps
- One sub-module, irc_cfg_shadow: the pending/active register pair and the apply logic, reusable by the IRC receiver's demod timer.

Test Plan:
1. Reset with defaults, mod_en=1, tx=0 for 6000 cycles → tx_mod high 1315 cycles, low 1316; first rising edge 1 cycle after the mark edge.
2. cfg_period=10, cfg_high=3, load in IDLE; mark of 25 cycles → pattern 3 high / 7 low ×2, then 3 high; idle after cycle 26; no truncated pulse.
3. Same config, mark drops at cnt=1 → TAIL, tx_mod stays high through cnt=2, then 0 and IDLE; mark returns at cnt=1 in TAIL → MARK continues with no phase reset.
4. Load period=20/high=10 mid-burst at cnt=4 of period 10 → cfg_pending=1 until cnt=9; next period is 10 high / 10 low.
5. Edge configs: cfg_period=1, cfg_high=5 → effective 2/1 (1 high / 1 low). cfg_high=0 → tx_mod stays 0 throughout the mark.
6. mod_en 1→0 mid-mark → next cycle tx_mod=tx, state IDLE; rst_n low during a pending load → defaults restored, cfg_pending=0.
